// File: rtl/uart_tx_fifo_drain_if.sv
// Read-side connection between the UART TX FIFO and its transmit drain.
interface uart_tx_fifo_drain_if;
   logic       fifo_empty;
   logic [7:0] fifo_data;
   logic       fifo_read_n;

   modport master (input fifo_empty, input fifo_data, output fifo_read_n);
   modport slave  (output fifo_empty, output fifo_data, input fifo_read_n);
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// UART TX FIFO drain: pops one byte at a time and serialises it as start, 7/8 data bits LSB first,
// optional parity and one stop bit. Define UART_TX_BREAK_EN to add break_req and a line-break state.
module uart_tx_fifo_drain #(
   parameter int READ_LATENCY = 2,
   parameter int OVERSAMPLE   = 16
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        baud_en,
   uart_tx_fifo_drain_if.master        fifo,
   input  logic                        bit8,
   input  logic                        parity_en,
   input  logic                        odd_n_even,
`ifdef UART_TX_BREAK_EN
   input  logic                        break_req,
`endif
   output logic                        tx,
   output logic                        tx_busy,
   output logic                        tx_done
);

   localparam logic [3:0] OS_LAST  = 4'(OVERSAMPLE - 1);
   localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY);

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_ISSUE    = 4'd1,
      ST_WAIT     = 4'd2,
      ST_START    = 4'd3,
      ST_DATA     = 4'd4,
      ST_PARITY   = 4'd5,
      ST_STOP     = 4'd6
`ifdef UART_TX_BREAK_EN
      ,
      ST_BREAK    = 4'd7,
      ST_BRK_IDLE = 4'd8
`endif
   } state_t;

   state_t     state_r;
   logic [3:0] os_cnt_r;
   logic [1:0] lat_cnt_r;
   logic [2:0] bit_cnt_r;
   logic [7:0] shift_r;
   logic       bit8_r;
   logic       par_en_r;
   logic       parity_r;
   logic       tx_r;
   logic       read_n_r;
   logic       busy_r;
   logic       done_r;

   logic       bit_end_s;
   logic       bit_state_s;
   logic [2:0] last_bit_s;
   logic [7:0] data_s;

   function automatic logic parity_f(input logic [7:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

   // 7-bit frames clear bit 7 at capture so it drops out of both shifting and parity.
   assign data_s      = bit8 ? fifo.fifo_data : {1'b0, fifo.fifo_data[6:0]};
   assign last_bit_s  = bit8_r ? 3'd7 : 3'd6;
   assign bit_end_s   = baud_en && (os_cnt_r == OS_LAST);
`ifdef UART_TX_BREAK_EN
   assign bit_state_s = (state_r == ST_START) || (state_r == ST_DATA) || (state_r == ST_PARITY) ||
                        (state_r == ST_STOP) || (state_r == ST_BRK_IDLE);
`else
   assign bit_state_s = (state_r == ST_START) || (state_r == ST_DATA) || (state_r == ST_PARITY) ||
                        (state_r == ST_STOP);
`endif

   assign fifo.fifo_read_n = read_n_r;
   assign tx               = tx_r;
   assign tx_busy          = busy_r;
   assign tx_done          = done_r;

   // Frame sequencer: every output is registered alongside the state transition that implies it.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         os_cnt_r  <= 4'd0;
         lat_cnt_r <= 2'd0;
         bit_cnt_r <= 3'd0;
         shift_r   <= 8'd0;
         bit8_r    <= 1'b0;
         par_en_r  <= 1'b0;
         parity_r  <= 1'b0;
         tx_r      <= 1'b1;
         read_n_r  <= 1'b1;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         done_r <= 1'b0;
         // The bit-time counter returns to 0 at each bit end, which is also every bit-state entry.
         if (bit_state_s && baud_en) begin
            os_cnt_r <= bit_end_s ? 4'd0 : os_cnt_r + 4'd1;
         end
         case (state_r)
            ST_IDLE: begin
`ifdef UART_TX_BREAK_EN
               if (break_req) begin
                  state_r <= ST_BREAK;
                  tx_r    <= 1'b0;
                  busy_r  <= 1'b1;
               end else if (!fifo.fifo_empty) begin
                  state_r  <= ST_ISSUE;
                  read_n_r <= 1'b0;
                  busy_r   <= 1'b1;
               end
`else
               if (!fifo.fifo_empty) begin
                  state_r  <= ST_ISSUE;
                  read_n_r <= 1'b0;
                  busy_r   <= 1'b1;
               end
`endif
            end
            ST_ISSUE: begin
               read_n_r  <= 1'b1;
               lat_cnt_r <= 2'd1;
               state_r   <= ST_WAIT;
            end
            ST_WAIT: begin
               if (lat_cnt_r == LAT_LAST) begin
                  shift_r  <= data_s;
                  bit8_r   <= bit8;
                  par_en_r <= parity_en;
                  parity_r <= parity_f(data_s, odd_n_even);
                  os_cnt_r <= 4'd0;
                  tx_r     <= 1'b0;
                  state_r  <= ST_START;
               end else begin
                  lat_cnt_r <= lat_cnt_r + 2'd1;
               end
            end
            ST_START: begin
               if (bit_end_s) begin
                  bit_cnt_r <= 3'd0;
                  tx_r      <= shift_r[0];
                  state_r   <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (bit_end_s) begin
                  if (bit_cnt_r == last_bit_s) begin
                     tx_r    <= par_en_r ? parity_r : 1'b1;
                     state_r <= par_en_r ? ST_PARITY : ST_STOP;
                  end else begin
                     shift_r   <= {1'b0, shift_r[7:1]};
                     tx_r      <= shift_r[1];
                     bit_cnt_r <= bit_cnt_r + 3'd1;
                  end
               end
            end
            ST_PARITY: begin
               if (bit_end_s) begin
                  tx_r    <= 1'b1;
                  state_r <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (bit_end_s) begin
                  done_r <= 1'b1;
`ifdef UART_TX_BREAK_EN
                  if (break_req) begin
                     state_r <= ST_BREAK;
                     tx_r    <= 1'b0;
                  end else if (!fifo.fifo_empty) begin
                     state_r  <= ST_ISSUE;
                     read_n_r <= 1'b0;
                  end else begin
                     state_r <= ST_IDLE;
                     busy_r  <= 1'b0;
                  end
`else
                  if (!fifo.fifo_empty) begin
                     state_r  <= ST_ISSUE;
                     read_n_r <= 1'b0;
                  end else begin
                     state_r <= ST_IDLE;
                     busy_r  <= 1'b0;
                  end
`endif
               end
            end
`ifdef UART_TX_BREAK_EN
            ST_BREAK: begin
               if (!break_req) begin
                  tx_r     <= 1'b1;
                  os_cnt_r <= 4'd0;
                  state_r  <= ST_BRK_IDLE;
               end
            end
            ST_BRK_IDLE: begin
               if (bit_end_s) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end
            end
`endif
            default: begin
               state_r  <= ST_IDLE;
               tx_r     <= 1'b1;
               read_n_r <= 1'b1;
               busy_r   <= 1'b0;
            end
         endcase
      end
   end

endmodule
